// File: rtl/imem_boot_sequencer_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : boot_seq_pkg
//  Description : Shared types and constants for the instruction-memory boot
//                sequencer (state encoding, riscv-tests exit convention).
//  Revision    : 1.0 - initial release
// ============================================================================
package boot_seq_pkg;

    // Sequencer states, explicitly encoded in 3 bits
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        FLUSH = 3'd2,
        RUN   = 3'd3,
        DONE  = 3'd4
    } state_t;

    // riscv-tests exit: a7 holds the exit ecall number, gp==1 means pass
    localparam int EXIT_A7      = 93;
    localparam int PASS_GP      = 1;

    // Cycles the core stays in reset between the last IMEM write and release
    localparam int FLUSH_CYCLES = 2;

endpackage
`default_nettype wire

// File: rtl/imem_boot_sequencer_if.sv
`default_nettype none
// ============================================================================
//  Module      : imem_boot_sequencer_if
//  Description : valid/ready program-image stream from the host loader into
//                the boot sequencer.
//                s_valid : image word valid (source -> sequencer)
//                s_data  : image word       (source -> sequencer)
//                s_ready : word accepted when s_valid & s_ready
//  Revision    : 1.0 - initial release
// ============================================================================
interface imem_boot_sequencer_if #(
    parameter int WIDTH = 32
);
    logic             s_valid;
    logic [WIDTH-1:0] s_data;
    logic             s_ready;

    // Image source side
    modport master (
        output s_valid,
        output s_data,
        input  s_ready
    );

    // Sequencer side
    modport slave (
        input  s_valid,
        input  s_data,
        output s_ready
    );
endinterface
`default_nettype wire

// File: rtl/imem_boot_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : imem_boot_sequencer
//  Description : Holds the RV32 core in reset, streams a program image into
//                instruction memory, releases the core and watches gp/a7 for
//                the riscv-tests exit convention. Reports pass/fail/timeout.
//  Ports       :
//    clock        in   rising-edge clock
//    reset        in   asynchronous active-low reset
//    start        in   launch pulse (accepted in IDLE or DONE)
//    abort        in   level, return to IDLE from any state
//    load_len     in   words to load (0 = run the existing image)
//    max_cycles   in   RUN budget (0 = unlimited)
//    s_if         if   image stream (slave modport)
//    insMemEn     out  IMEM write strobe
//    insMemAddr   out  IMEM word address
//    insMemDataIn out  IMEM write data
//    cpu_reset    out  active-high reset to the core
//    gp, a7       in   core registers x3 / x17
//    busy         out  LOAD, FLUSH or RUN
//    done         out  DONE
//    pass, timeout, len_err out  result flags, valid with done
//    cycles       out  RUN cycles elapsed
//  Revision    : 1.0 - initial release
// ============================================================================
module imem_boot_sequencer
    import boot_seq_pkg::*;
#(
    parameter int WIDTH      = 32,
    parameter int IMEM_DEPTH = 512,
    parameter int W_LEN      = $clog2(IMEM_DEPTH) + 1,
    parameter int W_CYC      = 24
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 abort,
    input  logic [W_LEN-1:0]     load_len,
    input  logic [W_CYC-1:0]     max_cycles,
    imem_boot_sequencer_if.slave s_if,
    output logic                 insMemEn,
    output logic [WIDTH-1:0]     insMemAddr,
    output logic [WIDTH-1:0]     insMemDataIn,
    output logic                 cpu_reset,
    input  logic [WIDTH-1:0]     gp,
    input  logic [WIDTH-1:0]     a7,
    output logic                 busy,
    output logic                 done,
    output logic                 pass,
    output logic                 timeout,
    output logic                 len_err,
    output logic [W_CYC-1:0]     cycles
);

    localparam logic [W_LEN-1:0] c_len_max   = W_LEN'(IMEM_DEPTH);
    localparam logic [1:0]       c_flush_end = 2'(FLUSH_CYCLES - 1);

    state_t           r_state;
    logic             r_s_ready;
    logic [W_LEN-1:0] r_len;
    logic [W_LEN-1:0] r_count;
    logic [1:0]       r_flush_cnt;

    logic w_handshake;
    logic w_last_word;
    logic w_exit;
    logic w_budget_end;

    assign s_if.s_ready = r_s_ready;

    assign w_handshake  = s_if.s_valid && r_s_ready;
    assign w_last_word  = (r_count == (r_len - W_LEN'(1)));
    assign w_exit       = (a7 == WIDTH'(EXIT_A7));
    assign w_budget_end = (max_cycles != '0) && (cycles == (max_cycles - W_CYC'(1)));

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state      <= IDLE;
            r_s_ready    <= 1'b0;
            r_len        <= '0;
            r_count      <= '0;
            r_flush_cnt  <= '0;
            insMemEn     <= 1'b0;
            insMemAddr   <= '0;
            insMemDataIn <= '0;
            cpu_reset    <= 1'b1;
            busy         <= 1'b0;
            done         <= 1'b0;
            pass         <= 1'b0;
            timeout      <= 1'b0;
            len_err      <= 1'b0;
            cycles       <= '0;
        end else if (abort) begin
            // A partially written image is left behind; the next start
            // reloads from address 0.
            r_state   <= IDLE;
            r_s_ready <= 1'b0;
            insMemEn  <= 1'b0;
            cpu_reset <= 1'b1;
            busy      <= 1'b0;
            done      <= 1'b0;
            pass      <= 1'b0;
            timeout   <= 1'b0;
            len_err   <= 1'b0;
        end else begin
            // Write strobe is a single-cycle pulse per accepted word
            insMemEn <= 1'b0;

            case (r_state)
                IDLE, DONE: begin
                    if (start) begin
                        pass    <= 1'b0;
                        timeout <= 1'b0;
                        len_err <= 1'b0;
                        cycles  <= '0;
                        if (load_len > c_len_max) begin
                            r_state <= DONE;
                            len_err <= 1'b1;
                            done    <= 1'b1;
                            busy    <= 1'b0;
                        end else if (load_len == '0) begin
                            r_state     <= FLUSH;
                            r_flush_cnt <= '0;
                            done        <= 1'b0;
                            busy        <= 1'b1;
                        end else begin
                            r_state   <= LOAD;
                            r_len     <= load_len;
                            r_count   <= '0;
                            r_s_ready <= 1'b1;
                            done      <= 1'b0;
                            busy      <= 1'b1;
                        end
                    end
                end

                LOAD: begin
                    if (w_handshake) begin
                        insMemEn     <= 1'b1;
                        insMemAddr   <= {{(WIDTH - W_LEN){1'b0}}, r_count};
                        insMemDataIn <= s_if.s_data;
                        r_count      <= r_count + W_LEN'(1);
                        if (w_last_word) begin
                            // The final write strobe is visible during the
                            // first FLUSH cycle and lands at its closing edge.
                            r_s_ready   <= 1'b0;
                            r_state     <= FLUSH;
                            r_flush_cnt <= '0;
                        end
                    end
                end

                FLUSH: begin
                    if (r_flush_cnt == c_flush_end) begin
                        r_state   <= RUN;
                        cpu_reset <= 1'b0;
                        cycles    <= '0;
                    end else begin
                        r_flush_cnt <= r_flush_cnt + 2'd1;
                    end
                end

                RUN: begin
                    if (cycles != '1) begin
                        cycles <= cycles + W_CYC'(1);
                    end
                    // Exit check has priority over the budget
                    if (w_exit) begin
                        r_state   <= DONE;
                        pass      <= (gp == WIDTH'(PASS_GP));
                        cpu_reset <= 1'b1;
                        busy      <= 1'b0;
                        done      <= 1'b1;
                    end else if (w_budget_end) begin
                        r_state   <= DONE;
                        timeout   <= 1'b1;
                        cpu_reset <= 1'b1;
                        busy      <= 1'b0;
                        done      <= 1'b1;
                    end
                end

                default: begin
                    r_state   <= IDLE;
                    r_s_ready <= 1'b0;
                    cpu_reset <= 1'b1;
                    busy      <= 1'b0;
                    done      <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_imem_boot_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_imem_boot_sequencer
//  Description : Scoreboard bench for imem_boot_sequencer. Stimulus pushes
//                expected IMEM writes and run results into queues; a monitor
//                pops and compares whenever the DUT writes or raises done.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_imem_boot_sequencer;

    localparam int WIDTH      = 32;
    localparam int IMEM_DEPTH = 512;
    localparam int W_LEN      = 10;
    localparam int W_CYC      = 24;

    typedef struct {
        logic [WIDTH-1:0] addr;
        logic [WIDTH-1:0] data;
    } wr_t;

    typedef struct {
        logic             pass;
        logic             timeout;
        logic             len_err;
        logic [W_CYC-1:0] cyc;
        bit               chk_cyc;
    } res_t;

    logic             clock      = 1'b0;
    logic             reset      = 1'b0;
    logic             start      = 1'b0;
    logic             abort      = 1'b0;
    logic [W_LEN-1:0] load_len   = '0;
    logic [W_CYC-1:0] max_cycles = '0;
    logic [WIDTH-1:0] gp         = '0;
    logic [WIDTH-1:0] a7         = '0;
    logic             insMemEn;
    logic [WIDTH-1:0] insMemAddr;
    logic [WIDTH-1:0] insMemDataIn;
    logic             cpu_reset;
    logic             busy;
    logic             done;
    logic             pass;
    logic             timeout;
    logic             len_err;
    logic [W_CYC-1:0] cycles;

    int checks   = 0;
    int failures = 0;

    wr_t  exp_wr[$];
    res_t exp_res[$];
    logic prev_done = 1'b0;

    imem_boot_sequencer_if #(.WIDTH(WIDTH)) s_if ();

    imem_boot_sequencer #(
        .WIDTH      (WIDTH),
        .IMEM_DEPTH (IMEM_DEPTH),
        .W_LEN      (W_LEN),
        .W_CYC      (W_CYC)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .start        (start),
        .abort        (abort),
        .load_len     (load_len),
        .max_cycles   (max_cycles),
        .s_if         (s_if),
        .insMemEn     (insMemEn),
        .insMemAddr   (insMemAddr),
        .insMemDataIn (insMemDataIn),
        .cpu_reset    (cpu_reset),
        .gp           (gp),
        .a7           (a7),
        .busy         (busy),
        .done         (done),
        .pass         (pass),
        .timeout      (timeout),
        .len_err      (len_err),
        .cycles       (cycles)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // ---------------- monitor / scoreboard ----------------
    always @(negedge clock) begin
        if (reset) begin
            if (insMemEn) begin
                if (exp_wr.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_write: addr 0x%0h data 0x%0h, expected no write",
                             insMemAddr, insMemDataIn);
                end else begin
                    wr_t e;
                    e = exp_wr.pop_front();
                    chk("wr_addr", insMemAddr, e.addr);
                    chk("wr_data", insMemDataIn, e.data);
                end
            end
            if (done && !prev_done) begin
                if (exp_res.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_done: pass %0b timeout %0b len_err %0b, expected no result",
                             pass, timeout, len_err);
                end else begin
                    res_t r;
                    r = exp_res.pop_front();
                    chk("res_pass", {31'd0, pass}, {31'd0, r.pass});
                    chk("res_timeout", {31'd0, timeout}, {31'd0, r.timeout});
                    chk("res_len_err", {31'd0, len_err}, {31'd0, r.len_err});
                    if (r.chk_cyc) chk("res_cycles", {8'd0, cycles}, {8'd0, r.cyc});
                    chk("done_cpu_reset", {31'd0, cpu_reset}, 32'd1);
                    chk("done_busy", {31'd0, busy}, 32'd0);
                end
            end
        end
        prev_done = done;
    end

    // ---------------- stimulus helpers ----------------
    task automatic launch(input logic [W_LEN-1:0] len, input logic [W_CYC-1:0] maxc);
        @(posedge clock); #1;
        start      = 1'b1;
        load_len   = len;
        max_cycles = maxc;
        @(posedge clock); #1;
        start = 1'b0;
    endtask

    // Streams n words base+i; pat[i] gives s_valid for cycle i, then held high.
    task automatic stream(input int n, input logic [31:0] base,
                          input logic [15:0] pat, input int patlen);
        int idx = 0;
        int cyc = 0;
        while (idx < n && cyc < 100) begin
            s_if.s_valid = (cyc < patlen) ? pat[cyc] : 1'b1;
            s_if.s_data  = base + idx;
            if (s_if.s_valid && s_if.s_ready) begin
                exp_wr.push_back('{addr: idx, data: base + idx});
                idx++;
            end
            cyc++;
            @(posedge clock); #1;
        end
        s_if.s_valid = 1'b0;
        if (idx < n) begin
            checks++;
            failures++;
            $display("FAIL stream_stall: accepted %0d words, required %0d", idx, n);
        end
    endtask

    // Called in the first FLUSH cycle: core released exactly 2 cycles later.
    task automatic check_flush();
        @(negedge clock);
        chk("flush0_cpu_reset", {31'd0, cpu_reset}, 32'd1);
        chk("flush0_busy", {31'd0, busy}, 32'd1);
        @(negedge clock);
        chk("flush1_cpu_reset", {31'd0, cpu_reset}, 32'd1);
        @(negedge clock);
        chk("run_cpu_reset", {31'd0, cpu_reset}, 32'd0);
        chk("run_busy", {31'd0, busy}, 32'd1);
    endtask

    task automatic wait_run_cycle(input logic [W_CYC-1:0] v);
        int n = 0;
        do begin
            @(negedge clock);
            n++;
        end while (!(cpu_reset == 1'b0 && cycles == v) && n < 300);
        if (!(cpu_reset == 1'b0 && cycles == v)) begin
            checks++;
            failures++;
            $display("FAIL wait_run_cycle: cycles 0x%0h, required 0x%0h", cycles, v);
        end
    endtask

    task automatic wait_done();
        int n = 0;
        while (!done && n < 500) begin
            @(negedge clock);
            n++;
        end
        if (!done) begin
            checks++;
            failures++;
            $display("FAIL wait_done: done %0b after %0d cycles, required 1", done, n);
        end
    endtask

    // ---------------- main sequence ----------------
    initial begin
        s_if.s_valid = 1'b0;
        s_if.s_data  = '0;

        // Reset state
        repeat (3) @(negedge clock);
        chk("rst_cpu_reset", {31'd0, cpu_reset}, 32'd1);
        chk("rst_s_ready", {31'd0, s_if.s_ready}, 32'd0);
        chk("rst_insMemEn", {31'd0, insMemEn}, 32'd0);
        chk("rst_addr", insMemAddr, 32'd0);
        chk("rst_data", insMemDataIn, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_flags", {29'd0, pass, timeout, len_err}, 32'd0);
        chk("rst_cycles", {8'd0, cycles}, 32'd0);
        reset = 1'b1;

        // T1: 4 back-to-back words, exit at cycle 10 with gp=1
        exp_res.push_back('{pass: 1'b1, timeout: 1'b0, len_err: 1'b0, cyc: 24'd10, chk_cyc: 1'b1});
        launch(10'd4, 24'd0);
        chk("load_s_ready", {31'd0, s_if.s_ready}, 32'd1);
        chk("load_busy", {31'd0, busy}, 32'd1);
        stream(4, 32'h0000_0013, 16'h000F, 4);
        check_flush();
        wait_run_cycle(24'd9);
        a7 = 32'd93;
        gp = 32'd1;
        wait_done();
        a7 = '0;
        gp = '0;

        // T2: gapped stream 1,0,1,1,0,1 then timeout at 20 cycles
        exp_res.push_back('{pass: 1'b0, timeout: 1'b1, len_err: 1'b0, cyc: 24'd20, chk_cyc: 1'b1});
        launch(10'd4, 24'd20);
        chk("relaunch_done", {31'd0, done}, 32'd0);
        stream(4, 32'h0000_00A0, 16'b10_1101, 6);
        check_flush();
        wait_done();

        // T3: load_len=0, exit on the last budget cycle wins over timeout
        exp_res.push_back('{pass: 1'b1, timeout: 1'b0, len_err: 1'b0, cyc: 24'd20, chk_cyc: 1'b1});
        launch(10'd0, 24'd20);
        check_flush();
        wait_run_cycle(24'd19);
        a7 = 32'd93;
        gp = 32'd1;
        wait_done();
        a7 = '0;
        gp = '0;

        // T4: exit with gp != 1 is a fail, no budget
        exp_res.push_back('{pass: 1'b0, timeout: 1'b0, len_err: 1'b0, cyc: 24'd5, chk_cyc: 1'b1});
        launch(10'd0, 24'd0);
        check_flush();
        wait_run_cycle(24'd4);
        a7 = 32'd93;
        gp = 32'd5;
        wait_done();
        a7 = '0;
        gp = '0;

        // T5: abort from DONE, then load_len=513 -> len_err, no write
        @(posedge clock); #1;
        abort = 1'b1;
        @(posedge clock); #1;
        abort = 1'b0;
        @(negedge clock);
        chk("abort_done", {31'd0, done}, 32'd0);
        chk("abort_flags", {29'd0, pass, timeout, len_err}, 32'd0);
        exp_res.push_back('{pass: 1'b0, timeout: 1'b0, len_err: 1'b1, cyc: 24'd0, chk_cyc: 1'b0});
        launch(10'd513, 24'd0);
        wait_done();
        chk("lenerr_busy", {31'd0, busy}, 32'd0);

        // T6: abort mid-LOAD after 2 words, then reload from address 0
        launch(10'd4, 24'd0);
        stream(2, 32'h0000_0300, 16'h0003, 2);
        abort = 1'b1;
        @(posedge clock); #1;
        abort = 1'b0;
        @(negedge clock);
        chk("abort_s_ready", {31'd0, s_if.s_ready}, 32'd0);
        chk("abort_insMemEn", {31'd0, insMemEn}, 32'd0);
        chk("abort_busy", {31'd0, busy}, 32'd0);
        chk("abort_cpu_reset", {31'd0, cpu_reset}, 32'd1);
        exp_res.push_back('{pass: 1'b1, timeout: 1'b0, len_err: 1'b0, cyc: 24'd3, chk_cyc: 1'b1});
        launch(10'd2, 24'd0);
        stream(2, 32'h0000_0400, 16'h0003, 2);
        check_flush();
        wait_run_cycle(24'd2);
        a7 = 32'd93;
        gp = 32'd1;
        wait_done();
        a7 = '0;
        gp = '0;

        // T7: asynchronous reset mid-RUN holds the core immediately
        launch(10'd0, 24'd0);
        wait_run_cycle(24'd3);
        #2;
        reset = 1'b0;
        #1;
        chk("async_cpu_reset", {31'd0, cpu_reset}, 32'd1);
        chk("async_busy", {31'd0, busy}, 32'd0);
        chk("async_cycles", {8'd0, cycles}, 32'd0);
        chk("async_insMemEn", {31'd0, insMemEn}, 32'd0);
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        chk("post_reset_cpu_reset", {31'd0, cpu_reset}, 32'd1);

        // All expected events consumed
        chk("wr_queue_empty", exp_wr.size(), 32'd0);
        chk("res_queue_empty", exp_res.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/imem_boot_sequencer.md
Name: imem_boot_sequencer

Overview:
- Sequences the single-cycle RV32 core for self-checking test runs.
- Holds the core in reset and streams a program image from a valid/ready source into instruction memory through the top-level insMemEn/insMemAddr/insMemDataIn write port.
- Releases the core, then watches gp/a7 for the riscv-tests exit convention (a7==93 ecall value, gp==1 means pass).
- Reports pass, fail or timeout; sits between the testbench/host loader and the processor top.

Parameters:
- WIDTH, 32, data word width.
- IMEM_DEPTH, 512, instruction memory depth in words.
- W_LEN, $clog2(IMEM_DEPTH)+1, width of the load-length input.
- W_CYC, 24, width of the run-cycle counter and timeout input.

Ports:
- clock  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-low; clears all state.
- start  in  1  one-cycle pulse; accepted only in IDLE or DONE.
- abort  in  1  level; forces return to IDLE from any state.
- load_len  in  W_LEN  number of words to load (0 = run existing image).
- max_cycles  in  W_CYC  run budget; 0 = no timeout.
- s_valid  in  1  image word valid.
- s_data  in  WIDTH  image word.
- s_ready  out  1  image word accepted when s_valid&s_ready.
- insMemEn  out  1  IMEM write strobe; the core executes NOP while high.
- insMemAddr  out  WIDTH  IMEM word address; zero-extended word index.
- insMemDataIn  out  WIDTH  IMEM write data.
- cpu_reset  out  1  active-high synchronous reset to the core.
- gp  in  WIDTH  core register x3.
- a7  in  WIDTH  core register x17.
- busy  out  1  high in LOAD, FLUSH, RUN.
- done  out  1  high in DONE.
- pass  out  1  valid when done; 1 iff exit seen with gp==1.
- timeout  out  1  valid when done; budget exhausted.
- len_err  out  1  valid when done; load_len > IMEM_DEPTH.
- cycles  out  W_CYC  RUN cycles elapsed; frozen in DONE.

Behaviour:
- Reset values (asynchronous, reset low): state IDLE, cpu_reset=1, s_ready=0, insMemEn=0, insMemAddr=0, insMemDataIn=0, busy=0, done=0, pass=0, timeout=0, len_err=0, cycles=0.
- All outputs are registered.
- States: IDLE, LOAD, FLUSH, RUN, DONE.
- IDLE:
  - cpu_reset=1.
  - On start with load_len > IMEM_DEPTH: go to DONE with len_err=1.
  - On start with load_len==0: go to FLUSH.
  - On start otherwise: go to LOAD, latch load_len, clear the word counter.
- LOAD:
  - cpu_reset=1, s_ready=1.
  - Each handshake at edge k: insMemEn=1, insMemAddr=count, insMemDataIn=s_data during cycle k+1; count increments.
  - No handshake: insMemEn=0 in the next cycle.
  - When the accepted word is number load_len-1: s_ready drops in the same registered update; go to FLUSH.
  - Back-to-back words: one per cycle, no bubbles.
- FLUSH:
  - Exactly 2 cycles, cpu_reset=1, insMemEn=0.
  - Guarantees the last IMEM write lands and the core PC is reset to 0 at a clock edge.
  - Then go to RUN; cycles cleared.
- RUN:
  - cpu_reset=0; cycles increments each cycle, saturating at all-ones.
  - a7==93 sampled: go to DONE, pass=(gp==1).
  - Else max_cycles!=0 and cycles==max_cycles-1: go to DONE, timeout=1.
  - If both conditions occur in the same cycle, the exit check wins (timeout=0).
- DONE:
  - cpu_reset=1, busy=0, done=1; result flags and cycles hold.
  - start re-launches exactly as from IDLE and clears the flags on the transition.
- start while busy: ignored.
- abort (any state, sampled on the edge): go to IDLE, cpu_reset=1, insMemEn=0, s_ready=0, flags cleared.
  - An aborted LOAD leaves partially written IMEM; this is allowed.
- Address generation: insMemAddr = count zero-extended to WIDTH. The counter never exceeds IMEM_DEPTH-1 because of the len_err check.
- Asynchronous reset mid-LOAD or mid-RUN: core held in reset immediately (cpu_reset=1 asynchronously); no write strobe survives.

Decomposition:
- Package boot_seq_pkg:
  - state enum (IDLE, LOAD, FLUSH, RUN, DONE).
  - localparams EXIT_A7=93, PASS_GP=1, FLUSH_CYCLES=2.
- No sub-module required; the word counter and cycle counter are inline.

Test Plan:
- Load 4 words 0x00000013..0x00000013+3 with s_valid held high: 4 consecutive insMemEn pulses, addr 0,1,2,3. FLUSH lasts 2 cycles, then cpu_reset falls; busy=1 throughout.
- Gapped stream (s_valid toggling 1,0,1,1,0,1 for load_len=4): insMemEn only after accepted beats; addresses contiguous 0..3; no extra write.
- RUN with a7 forced to 93 and gp=1 at cycle 10: done=1, pass=1, timeout=0, cycles=10 (±1 per counter definition), cpu_reset=1.
- max_cycles=20 and a7 never 93: done after 20 RUN cycles with timeout=1, pass=0. Repeat with a7=93 on the final cycle: pass per gp, timeout=0.
- load_len=513: immediate DONE with len_err=1, no insMemEn pulse. load_len=0: straight to FLUSH then RUN.
- abort asserted mid-LOAD after 2 words: next cycle state IDLE, s_ready=0, insMemEn=0. A subsequent start reloads from address 0.
